// File: rtl/sram_model_clocked_if.sv
// sram_model_clocked_if: asynchronous-SRAM style bus between a bus master and the clocked SRAM model
interface sram_model_clocked_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic [AW-1:0] a;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out;
  logic d_oe;
  logic ce_n;
  logic oe_n;
  logic we_n;
  logic busy;
  logic err_short_wr;
  logic err_addr_wr;
  modport master (
    output a, d_in, ce_n, oe_n, we_n,
    input d_out, d_oe, busy, err_short_wr, err_addr_wr
  );
  modport slave (
    input a, d_in, ce_n, oe_n, we_n,
    output d_out, d_oe, busy, err_short_wr, err_addr_wr
  );
endinterface

// File: rtl/sram_model_clocked.sv
// sram_model_clocked: cycle-counted byte SRAM model with power-on fill and bus-timing error flags
module sram_model_clocked #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1,
  parameter int INIT_MODE = 1
) (
  input logic clk24,
  input logic master_reset,
  sram_model_clocked_if.slave bus
);
  typedef enum logic [2:0] {INIT, IDLE, RD_WAIT, RD_VALID, WR_ACT} state_t;
  localparam int MX = RD_LAT > WR_LAT ? RD_LAT : WR_LAT;
  localparam int CW = $clog2(MX + 1);
  logic [DW-1:0] mem [2**AW];
  state_t state, state_n;
  logic [AW-1:0] ptr, a_reg;
  logic [DW-1:0] d_reg, d_out, pat;
  logic [CW-1:0] rd_cnt, wr_cnt;
  logic d_oe, err_short_wr, err_addr_wr, wr_req, rd_req, a_chg;
  assign wr_req = !bus.ce_n && !bus.we_n;
  assign rd_req = !bus.ce_n && !bus.oe_n;
  assign a_chg = bus.a != a_reg;
  assign pat = INIT_MODE == 0 ? '0 : INIT_MODE == 1 ? {ptr[AW-1 -: 2], ptr[DW-3:0]} : ptr[DW-1:0];
  assign bus.d_out = d_out;
  assign bus.d_oe = d_oe;
  assign bus.busy = state == INIT;
  assign bus.err_short_wr = err_short_wr;
  assign bus.err_addr_wr = err_addr_wr;
  // next state: writes win over reads, a dropped enable returns to idle
  always_comb begin
    state_n = state;
    case (state)
      INIT:     state_n = ptr == '1 ? IDLE : INIT;
      IDLE:     state_n = wr_req ? WR_ACT : rd_req ? RD_WAIT : IDLE;
      RD_WAIT:  state_n = wr_req ? WR_ACT : !rd_req ? IDLE : (!a_chg && rd_cnt == CW'(RD_LAT)) ? RD_VALID : RD_WAIT;
      RD_VALID: state_n = wr_req ? WR_ACT : !rd_req ? IDLE : a_chg ? RD_WAIT : RD_VALID;
      WR_ACT:   state_n = wr_req ? WR_ACT : IDLE;
      default:  state_n = INIT;
    endcase
  end
  // state register, fill sweep, address/data latches, memory commit and error pulses
  always_ff @(posedge clk24) begin
    if (master_reset) begin
      state <= INIT;
      ptr <= '0;
      a_reg <= '0;
      d_reg <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      d_out <= '0;
      d_oe <= 1'b0;
      err_short_wr <= 1'b0;
      err_addr_wr <= 1'b0;
    end else begin
      state <= state_n;
      err_short_wr <= 1'b0;
      err_addr_wr <= 1'b0;
      d_oe <= state_n == RD_VALID;
      if (state == INIT) begin
        mem[ptr] <= pat;
        ptr <= ptr + AW'(1);
      end
      if (state == RD_WAIT && state_n == RD_VALID)
        d_out <= mem[a_reg];
      if (state_n == RD_WAIT && (state != RD_WAIT || a_chg)) begin
        a_reg <= bus.a;
        rd_cnt <= CW'(1);
      end else if (state == RD_WAIT && state_n == RD_WAIT)
        rd_cnt <= rd_cnt + CW'(1);
      if (state != WR_ACT && state_n == WR_ACT) begin
        a_reg <= bus.a;
        d_reg <= bus.d_in;
        wr_cnt <= CW'(1);
      end
      if (state == WR_ACT) begin
        if (!wr_req) begin
          if (wr_cnt >= CW'(WR_LAT))
            mem[a_reg] <= d_reg;
          else
            err_short_wr <= 1'b1;
        end else begin
          d_reg <= bus.d_in;
          if (a_chg) begin
            err_addr_wr <= 1'b1;
            a_reg <= bus.a;
            wr_cnt <= CW'(1);
          end else
            wr_cnt <= wr_cnt == CW'(WR_LAT) ? wr_cnt : wr_cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_sram_model_clocked.sv
// tb_sram_model_clocked: randomized bus traffic against a run-length memory model plus literal spot checks
module tb_sram_model_clocked;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;
  logic clk24, master_reset;
  int checks = 0, failures = 0;
  sram_model_clocked_if #(.AW(AW), .DW(8)) bus ();
  sram_model_clocked #(.AW(AW), .DW(8), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .INIT_MODE(1)) dut (
    .clk24(clk24),
    .master_reset(master_reset),
    .bus(bus)
  );
  initial clk24 = 1'b0;
  always #5 clk24 = ~clk24;
  logic [7:0] mmem [DEPTH];
  logic started = 1'b0;
  int busy_left = 0, rd_run = 0, wr_run = 0;
  logic [AW-1:0] ra, wa;
  logic [7:0] wd, m_dout;
  logic m_esw, m_eaw;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model: a read is valid once the same address has been requested for RD_LAT+1 edges;
  // a write commits when its low-run reaches WR_LAT, and the ending edge is consumed
  always @(posedge clk24) begin
    if (master_reset) begin
      started = 1'b1;
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mmem[i] = 8'(((i >> 8) & 3) * 64 + (i & 63));
      rd_run = 0;
      wr_run = 0;
      m_dout = 8'h00;
      m_esw = 1'b0;
      m_eaw = 1'b0;
    end else if (started) begin
      m_esw = 1'b0;
      m_eaw = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        rd_run = 0;
        wr_run = 0;
      end else if (!bus.ce_n && !bus.we_n) begin
        rd_run = 0;
        if (wr_run > 0 && bus.a != wa) m_eaw = 1'b1;
        wr_run = (wr_run == 0 || bus.a != wa) ? 1 : (wr_run < 50 ? wr_run + 1 : 50);
        wa = bus.a;
        wd = bus.d_in;
      end else if (wr_run > 0) begin
        if (wr_run >= WR_LAT) mmem[wa] = wd;
        else m_esw = 1'b1;
        wr_run = 0;
        rd_run = 0;
      end else if (!bus.ce_n && !bus.oe_n) begin
        rd_run = (rd_run > 0 && bus.a == ra) ? (rd_run < 50 ? rd_run + 1 : 50) : 1;
        ra = bus.a;
        if (rd_run == RD_LAT + 1) m_dout = mmem[ra];
      end else
        rd_run = 0;
    end
  end
  // per-cycle comparison of every output against the model
  always @(negedge clk24) begin
    if (started) begin
      chk("busy", bus.busy, busy_left > 0);
      chk("d_oe", bus.d_oe, rd_run > RD_LAT);
      chk("d_out", bus.d_out, m_dout);
      chk("err_short_wr", bus.err_short_wr, m_esw);
      chk("err_addr_wr", bus.err_addr_wr, m_eaw);
    end
  end
  task automatic tick;
    @(posedge clk24);
    #1;
  endtask
  task automatic idle;
    bus.ce_n = 1'b1;
    bus.oe_n = 1'b1;
    bus.we_n = 1'b1;
  endtask
  task automatic read_chk(input logic [AW-1:0] ad, input logic [7:0] exp, input string nm);
    int n;
    bus.a = ad;
    bus.ce_n = 1'b0;
    bus.oe_n = 1'b0;
    bus.we_n = 1'b1;
    n = 0;
    tick;
    while (!bus.d_oe && n < 10) begin
      n++;
      tick;
    end
    chk({nm, "_doe"}, bus.d_oe, 1);
    chk(nm, bus.d_out, exp);
    idle;
    tick;
  endtask
  task automatic write(input logic [AW-1:0] ad, input logic [7:0] d, input int len);
    bus.a = ad;
    bus.d_in = d;
    bus.ce_n = 1'b0;
    bus.oe_n = 1'b1;
    bus.we_n = 1'b0;
    repeat (len) tick;
    idle;
    tick;
  endtask
  task automatic wait_fill(input string nm);
    int n;
    n = 0;
    while (bus.busy && n < 3000) begin
      n++;
      tick;
    end
    chk(nm, bus.busy, 0);
  endtask
  initial begin
    int n, op, len;
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, op, len;
    master_reset = 1'b1;
    idle;
    bus.a = '0;
    bus.d_in = '0;
    tick;
    tick;
    master_reset = 1'b0;
    n = 0;
    while (bus.busy && n < 2000) begin
      n++;
      tick;
    end
    chk("fill_busy_cycles", n, DEPTH);
    read_chk(10'h33F, 8'hFF, "fill_33f");
    read_chk(10'h105, 8'h45, "fill_105");
    bus.a = 10'h010;
    bus.ce_n = 1'b0;
    bus.oe_n = 1'b0;
    tick;
    chk("lat_edge0_doe", bus.d_oe, 0);
    tick;
    chk("lat_edge1_doe", bus.d_oe, 0);
    tick;
    chk("lat_edge2_doe", bus.d_oe, 1);
    chk("lat_edge2_dout", bus.d_out, 8'h10);
    idle;
    tick;
    write(10'h234, 8'hA5, 2);
    read_chk(10'h234, 8'hA5, "write_234");
    write(10'h001, 8'h77, 1);
    chk("short_wr_pulse", bus.err_short_wr, 1);
    tick;
    chk("short_wr_clear", bus.err_short_wr, 0);
    read_chk(10'h001, 8'h01, "short_wr_001");
    bus.a = 10'h002;
    bus.d_in = 8'h5A;
    bus.ce_n = 1'b0;
    bus.we_n = 1'b0;
    tick;
    bus.a = 10'h003;
    tick;
    chk("addr_wr_pulse", bus.err_addr_wr, 1);
    tick;
    idle;
    tick;
    read_chk(10'h003, 8'h5A, "glitch_003");
    read_chk(10'h002, 8'h02, "glitch_002");
    for (int t = 0; t < 400; t++) begin
      op = $urandom_range(0, 2);
      len = $urandom_range(1, 5);
      bus.a = 10'($urandom_range(0, 31));
      if (op == 0) begin
        bus.ce_n = 1'b0;
        bus.oe_n = 1'b0;
        bus.we_n = 1'b1;
        repeat (len) begin
          if ($urandom_range(0, 7) == 0) bus.a = 10'($urandom_range(0, 31));
          tick;
        end
      end else if (op == 1) begin
        bus.ce_n = 1'b0;
        bus.we_n = 1'b0;
        bus.oe_n = 1'($urandom_range(0, 1));
        repeat (len > 3 ? 3 : len) begin
          bus.d_in = 8'($urandom);
          if ($urandom_range(0, 5) == 0) bus.a = 10'($urandom_range(0, 31));
          tick;
        end
      end else begin
        bus.ce_n = 1'($urandom_range(0, 1));
        bus.oe_n = 1'($urandom_range(0, 1));
        bus.we_n = 1'b1;
        tick;
      end
    end
    idle;
    tick;
    tick;
    bus.a = 10'h010;
    bus.d_in = 8'hEE;
    bus.ce_n = 1'b0;
    bus.we_n = 1'b0;
    tick;
    tick;
    master_reset = 1'b1;
    tick;
    chk("rst_wr_busy", bus.busy, 1);
    chk("rst_wr_doe", bus.d_oe, 0);
    master_reset = 1'b0;
    idle;
    wait_fill("rst_wr_fill");
    read_chk(10'h010, 8'h10, "rst_wr_discard");
    bus.a = 10'h234;
    bus.ce_n = 1'b0;
    bus.oe_n = 1'b0;
    tick;
    tick;
    master_reset = 1'b1;
    tick;
    chk("rst_rd_busy", bus.busy, 1);
    chk("rst_rd_doe", bus.d_oe, 0);
    master_reset = 1'b0;
    idle;
    wait_fill("rst_rd_fill");
    read_chk(10'h234, 8'hB4, "rst_refill_234");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
